// File: rtl/reg5_arb_pkg.sv
// Shared definitions for the reg5 access arbiter: FSM state encoding and default sizes.
// Optional lock feature of the arbiter is enabled with `define REG5_ARB_LOCK_EN.
package reg5_arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 5;
  localparam int IDXW_DEF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/reg5_access_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping at NREQ.
module rr_pick
  import reg5_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDXW = IDXW_DEF
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic [IDXW-1:0] o_winner,
  output logic            o_valid
);

  int w_idx;

  // Scan from the farthest candidate back to i_ptr so the nearest hit is written last.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = int'(i_ptr) + i;
      if (w_idx >= NREQ) begin
        w_idx = w_idx - NREQ;
      end
      if (i_req[w_idx]) begin
        o_winner = IDXW'(w_idx);
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg5_access_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among NREQ writers.
// Define REG5_ARB_LOCK_EN to add the lock port for back-to-back writes by one owner.
module reg5_access_arbiter
  import reg5_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDXW  = IDXW_DEF
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
`ifdef REG5_ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic [IDXW-1:0]       owner,
  output logic                  busy
);

  state_t            r_state;
  state_t            w_stateNext;
  logic [IDXW-1:0]   r_ptr;
  logic [IDXW-1:0]   r_owner;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_ack;
  logic [WIDTH-1:0]  r_q;

  logic [IDXW-1:0]   w_ptrNext;
  logic [IDXW-1:0]   w_ownerNext;
  logic [NREQ-1:0]   w_gntNext;
  logic [NREQ-1:0]   w_ackNext;
  logic [WIDTH-1:0]  w_qNext;

  logic [IDXW-1:0]   w_winner;
  logic              w_valid;
  logic [WIDTH-1:0]  w_lane;
  logic [IDXW-1:0]   w_ptrWrap;
  logic              w_lockHold;

  function automatic logic [NREQ-1:0] oneHot(input logic [IDXW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  assign w_lane    = din[r_owner*WIDTH +: WIDTH];
  assign w_ptrWrap = (r_owner == IDXW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

`ifdef REG5_ARB_LOCK_EN
  assign w_lockHold = lock[r_owner] & req[r_owner];
`else
  assign w_lockHold = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: if (w_valid) w_stateNext = ST_LOAD;
      ST_LOAD: w_stateNext = ST_ACK;
      ST_ACK:  w_stateNext = w_lockHold ? ST_LOAD : ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; the pointer is untouched while a lock repeats LOAD.
  always_comb begin
    w_gntNext   = r_gnt;
    w_ackNext   = r_ack;
    w_ownerNext = r_owner;
    w_ptrNext   = r_ptr;
    w_qNext     = r_q;
    case (r_state)
      ST_IDLE: begin
        w_ackNext = '0;
        if (w_valid) begin
          w_ownerNext = w_winner;
          w_gntNext   = oneHot(w_winner);
        end else begin
          w_gntNext = '0;
        end
      end
      ST_LOAD: begin
        w_qNext   = w_lane;
        w_gntNext = '0;
        w_ackNext = oneHot(r_owner);
        w_ptrNext = w_ptrWrap;
      end
      ST_ACK: begin
        w_ackNext = '0;
        w_gntNext = w_lockHold ? oneHot(r_owner) : '0;
      end
      default: begin
        w_gntNext = '0;
        w_ackNext = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_gnt   <= '0;
      r_ack   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_q     <= '0;
    end else begin
      r_gnt   <= w_gntNext;
      r_ack   <= w_ackNext;
      r_owner <= w_ownerNext;
      r_ptr   <= w_ptrNext;
      r_q     <= w_qNext;
    end
  end

  assign gnt   = r_gnt;
  assign ack   = r_ack;
  assign q     = r_q;
  assign owner = r_owner;
  assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_reg5_access_arbiter.sv
// Bench for reg5_access_arbiter: directed scenarios plus random traffic against a transaction model.
// Lock scenario is included when REG5_ARB_LOCK_EN is defined.
module tb_reg5_access_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 5;
  localparam int IDXW  = 2;

  logic                  clock = 1'b0;
  logic                  resetn = 1'b0;
  logic [NREQ-1:0]       reqV = '0;
  logic [NREQ*WIDTH-1:0] dinV = '0;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic [IDXW-1:0]       owner;
  logic                  busy;
`ifdef REG5_ARB_LOCK_EN
  logic [NREQ-1:0]       lockV = '0;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Model state: round-robin pointer and register contents, tracked per transaction.
  int               mPtr = 0;
  logic [WIDTH-1:0] mQ   = '0;

  reg5_access_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .req    (reqV),
    .din    (dinV),
`ifdef REG5_ARB_LOCK_EN
    .lock   (lockV),
`endif
    .gnt    (gnt),
    .ack    (ack),
    .q      (q),
    .owner  (owner),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d);
    reqV = r;
    dinV = d;
  endtask

  task automatic resetDut();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    mPtr = 0;
    mQ   = '0;
  endtask

  // One arbitration round from IDLE, with expectations derived from the round-robin rule.
  task automatic doTransaction(input bit dropInLoad, input bit keepReq);
    int  w;
    bit  found;
    found = 1'b0;
    w     = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && reqV[(mPtr + i) % NREQ]) begin
        w     = (mPtr + i) % NREQ;
        found = 1'b1;
      end
    end
    if (!found) begin
      tick();
      checkOutput("idle_gnt", 32'(gnt), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_q", 32'(q), 32'(mQ));
      return;
    end
    tick();
    checkOutput("grant_gnt", 32'(gnt), 32'(1 << w));
    checkOutput("grant_owner", 32'(owner), 32'(w));
    checkOutput("grant_busy", 32'(busy), 32'd1);
    checkOutput("grant_ack", 32'(ack), 32'd0);
    checkOutput("grant_q", 32'(q), 32'(mQ));
    if (dropInLoad) reqV[w] = 1'b0;
    mQ = dinV[w*WIDTH +: WIDTH];
    tick();
    checkOutput("load_q", 32'(q), 32'(mQ));
    checkOutput("load_ack", 32'(ack), 32'(1 << w));
    checkOutput("load_gnt", 32'(gnt), 32'd0);
    mPtr = (w + 1) % NREQ;
    if (!keepReq) reqV[w] = 1'b0;
    tick();
    checkOutput("ack_ack", 32'(ack), 32'd0);
    checkOutput("ack_gnt", 32'(gnt), 32'd0);
    checkOutput("ack_busy", 32'(busy), 32'd0);
    checkOutput("ack_q", 32'(q), 32'(mQ));
  endtask

  initial begin
    // Reset with every requester asking.
    applyStimulus(4'b1111, 20'($urandom));
    resetn = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checkOutput("rst_q", 32'(q), 32'd0);
      checkOutput("rst_gnt", 32'(gnt), 32'd0);
      checkOutput("rst_ack", 32'(ack), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_owner", 32'(owner), 32'd0);
    end
    resetn = 1'b1;
    mPtr = 0;
    mQ   = '0;

    // Single requester 2 with lane value 0x15.
    applyStimulus(4'b0100, {5'h00, 5'h15, 5'h00, 5'h00});
    doTransaction(1'b0, 1'b0);
    checkOutput("single_q", 32'(q), 32'h15);

    // Contention with all requests held: service order 0,1,2,3.
    resetDut();
    applyStimulus(4'b1111, {5'h04, 5'h03, 5'h02, 5'h01});
    for (int k = 0; k < 4; k++) begin
      doTransaction(1'b0, 1'b1);
      checkOutput("contend_q", 32'(q), 32'(k + 1));
      checkOutput("contend_owner", 32'(owner), 32'(k));
    end

    // Fairness: after requester 1, pattern 0011 wraps to requester 0, then 1.
    resetDut();
    applyStimulus(4'b0010, {5'h00, 5'h00, 5'h0C, 5'h00});
    doTransaction(1'b0, 1'b0);
    applyStimulus(4'b0011, {5'h00, 5'h00, 5'h0D, 5'h0E});
    doTransaction(1'b0, 1'b1);
    checkOutput("fair_owner0", 32'(owner), 32'd0);
    checkOutput("fair_ptr", 32'(mPtr), 32'd1);
    doTransaction(1'b0, 1'b0);
    checkOutput("fair_owner1", 32'(owner), 32'd1);

    // Reset arriving during LOAD aborts the write.
    resetDut();
    applyStimulus(4'b1000, {5'h1F, 5'h00, 5'h00, 5'h00});
    tick();
    checkOutput("abort_gnt", 32'(gnt), 32'b1000);
    resetn = 1'b0;
    tick();
    checkOutput("abort_q", 32'(q), 32'd0);
    checkOutput("abort_ack", 32'(ack), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    applyStimulus(4'b0000, {5'h1F, 5'h00, 5'h00, 5'h00});
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("abort_post_ack", 32'(ack), 32'd0);
      checkOutput("abort_post_busy", 32'(busy), 32'd0);
      checkOutput("abort_post_q", 32'(q), 32'd0);
    end
    mPtr = 0;
    mQ   = '0;

`ifdef REG5_ARB_LOCK_EN
    // Locked owner 2 writes twice back to back, then requester 1 wins.
    resetDut();
    applyStimulus(4'b0010, {5'h00, 5'h00, 5'h00, 5'h00});
    doTransaction(1'b0, 1'b0);
    lockV = 4'b0100;
    applyStimulus(4'b0110, {5'h00, 5'h0A, 5'h07, 5'h00});
    tick();
    checkOutput("lock_gnt0", 32'(gnt), 32'b0100);
    tick();
    checkOutput("lock_q0", 32'(q), 32'h0A);
    checkOutput("lock_ack0", 32'(ack), 32'b0100);
    dinV[2*WIDTH +: WIDTH] = 5'h0B;
    tick();
    checkOutput("lock_gnt1", 32'(gnt), 32'b0100);
    checkOutput("lock_ack_gap", 32'(ack), 32'd0);
    checkOutput("lock_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("lock_q1", 32'(q), 32'h0B);
    checkOutput("lock_ack1", 32'(ack), 32'b0100);
    lockV   = '0;
    reqV[2] = 1'b0;
    tick();
    checkOutput("lock_exit_busy", 32'(busy), 32'd0);
    mQ   = 5'h0B;
    mPtr = 3;
    doTransaction(1'b0, 1'b0);
    checkOutput("lock_next_owner", 32'(owner), 32'd1);
`endif

    // Random traffic, including requests dropped during LOAD.
    resetDut();
    for (int t = 0; t < 40; t++) begin
      applyStimulus(4'($urandom_range(0, 15)), 20'($urandom));
      doTransaction(1'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
